// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM download / game read arbiter.
// Imported by the arbiter top; the FIFO stays type-agnostic.
package jtframe_dwnld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR     = 2'd1,
        ST_RD     = 2'd2,
        ST_RDWAIT = 2'd3
    } state_t;

    // Byte-disable masks, active high, bit 0 = low byte
    localparam logic [1:0] MASK_FULL = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    function automatic logic [15:0] lo_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO holding assembled SDRAM write words.
// Full/empty use one extra pointer bit; push on full succeeds with a pop.
module jtframe_dwnld_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_drop
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW:0]  r_wp;
    logic [PW:0]  r_rp;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[PW] != r_rp[PW]) &&
                       (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_dout    = r_mem[r_rp[PW-1:0]];

    // Pointer update; wrap is implicit in the modulo-2*DEPTH counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[PW-1:0]] <= i_din;
    end

endmodule

// File: rtl/jtframe_dwnld_arb.sv
// Packs download bytes into 16-bit SDRAM writes and arbitrates them
// against game reads; writes always win over reads.
module jtframe_dwnld_arb
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [15:0]   rd_data,
    output logic          sdram_req,
    output logic          sdram_wrn,
    output logic [AW-1:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_mask,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_dout,
    output logic          overflow
);
    localparam int EW = AW + 18;

    state_t        r_state;
    state_t        w_next;
    logic          r_pend;
    logic [AW-1:0] r_lat_addr;
    logic [7:0]    r_lat_byte;
    logic          r_dl_q;
    logic          r_overflow;
    logic          r_rd_valid;
    logic [15:0]   r_rd_data;

    logic [AW-1:0] w_waddr;
    logic          w_even;
    logic          w_match;
    logic          w_fall;
    logic          w_push;
    logic [AW-1:0] w_push_addr;
    logic [15:0]   w_push_din;
    logic [1:0]    w_push_mask;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;

    assign w_waddr = ioctl_addr[AW:1];
    assign w_even  = ~ioctl_addr[0];
    assign w_match = r_pend && (r_lat_addr == w_waddr);
    assign w_fall  = r_dl_q && !downloading;

    generate
        if (AW < 24) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^ioctl_addr[24:AW+1];
        end
    endgenerate

    // Decide what word, if any, enters the FIFO this cycle
    always_comb begin
        w_push      = 1'b0;
        w_push_addr = '0;
        w_push_din  = '0;
        w_push_mask = MASK_NONE;
        if (ioctl_wr) begin
            if (w_even) begin
                if (r_pend) begin
                    w_push      = 1'b1;
                    w_push_addr = r_lat_addr;
                    w_push_din  = lo_word(r_lat_byte);
                    w_push_mask = MASK_LO;
                end
            end else if (w_match) begin
                w_push      = 1'b1;
                w_push_addr = w_waddr;
                w_push_din  = {ioctl_data, r_lat_byte};
                w_push_mask = MASK_FULL;
            end else begin
                w_push      = 1'b1;
                w_push_addr = w_waddr;
                w_push_din  = {ioctl_data, 8'h00};
                w_push_mask = MASK_HI;
            end
        end else if (w_fall && r_pend) begin
            w_push      = 1'b1;
            w_push_addr = r_lat_addr;
            w_push_din  = lo_word(r_lat_byte);
            w_push_mask = MASK_LO;
        end
    end

    // Low-byte latch and the pending flag for a half-built word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_lat_addr <= '0;
            r_lat_byte <= '0;
        end else if (ioctl_wr) begin
            if (w_even) begin
                r_pend     <= 1'b1;
                r_lat_addr <= w_waddr;
                r_lat_byte <= ioctl_data;
            end else if (w_match) begin
                r_pend <= 1'b0;
            end
        end else if (w_fall) begin
            r_pend <= 1'b0;
        end
    end

    // Download edge tracking and the sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_q     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_dl_q <= downloading;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    jtframe_dwnld_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({w_push_addr, w_push_din, w_push_mask}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state; a push arriving this cycle already claims the bus
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty || w_push)         w_next = ST_WR;
                else if (rd_req && !downloading) w_next = ST_RD;
            end
            ST_WR:     if (sdram_ack) w_next = ST_IDLE;
            ST_RD:     if (sdram_ack) w_next = ST_RDWAIT;
            ST_RDWAIT: if (sdram_dst) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus outputs; idle values equal the reset values
    always_comb begin
        sdram_req  = 1'b0;
        sdram_wrn  = 1'b1;
        sdram_addr = '0;
        sdram_din  = '0;
        sdram_mask = MASK_NONE;
        rd_ack     = 1'b0;
        w_pop      = 1'b0;
        unique case (r_state)
            ST_WR: begin
                sdram_req  = 1'b1;
                sdram_wrn  = 1'b0;
                sdram_addr = w_head[EW-1:18];
                sdram_din  = w_head[17:2];
                sdram_mask = w_head[1:0];
                w_pop      = sdram_ack;
            end
            ST_RD: begin
                sdram_req  = 1'b1;
                sdram_addr = rd_addr;
                rd_ack     = sdram_ack;
            end
            default: ;
        endcase
    end

    // Read data capture and its one-cycle valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= (r_state == ST_RDWAIT) && sdram_dst;
            if ((r_state == ST_RDWAIT) && sdram_dst)
                r_rd_data <= sdram_dout;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_jtframe_dwnld_arb.sv
// Bench for jtframe_dwnld_arb: directed scenarios plus random downloads
// compared against a byte-stream word model and an SDRAM responder.
module tb_jtframe_dwnld_arb;
  localparam int AW = 22;
  typedef logic [AW+17:0] wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic ioctl_wr = 1'b0;
  logic rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic sdram_req, sdram_wrn;
  logic [AW-1:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0] sdram_mask;
  logic sdram_ack = 1'b0;
  logic sdram_dst = 1'b0;
  logic [15:0] sdram_dout = 16'hBEEF;
  logic overflow;

  jtframe_dwnld_arb #(.AW(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .sdram_req(sdram_req), .sdram_wrn(sdram_wrn),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_mask(sdram_mask), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_dout(sdram_dout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  wr_t got_w[$];
  wr_t exp_w[$];
  logic [AW-1:0] got_r[$];
  int ev_q[$];
  int errs = 0;
  int checks = 0;
  bit ack_en = 1'b1;
  int dst_lat = 2;
  int dst_cnt = 0;
  int vcnt = 0;
  int acnt = 0;
  int viol = 0;
  bit m_pend = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0] m_byte = '0;
  logic p_req = 1'b0;
  logic p_ack = 1'b0;
  logic [AW+18:0] p_bus = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Word-level model of byte packing
  task automatic model_byte(logic [24:0] a, logic [7:0] d);
    logic [AW-1:0] w;
    w = a[AW:1];
    if (!a[0]) begin
      if (m_pend) exp_w.push_back({m_addr, 8'h00, m_byte, 2'b10});
      m_pend = 1'b1;
      m_addr = w;
      m_byte = d;
    end else if (m_pend && m_addr == w) begin
      exp_w.push_back({w, d, m_byte, 2'b00});
      m_pend = 1'b0;
    end else begin
      exp_w.push_back({w, d, 8'h00, 2'b01});
    end
  endtask

  task automatic model_end();
    if (m_pend) exp_w.push_back({m_addr, 8'h00, m_byte, 2'b10});
    m_pend = 1'b0;
  endtask

  task automatic send_byte(logic [24:0] a, logic [7:0] d, int gap);
    model_byte(a, d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    tick(gap);
  endtask

  task automatic end_dl();
    model_end();
    downloading = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_pend = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_writes();
    for (int i = 0; i < 300; i++) begin
      if (got_w.size() >= exp_w.size() && !sdram_req) break;
      tick(1);
    end
    tick(2);
  endtask

  task automatic drain_check(string tag);
    int n;
    wait_writes();
    chk({tag, "_nwr"}, got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), got_w[i], exp_w[i]);
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"}, sdram_req, 1'b0);
    chk({tag, "_wrn"}, sdram_wrn, 1'b1);
    chk({tag, "_addr"}, sdram_addr, '0);
    chk({tag, "_din"}, sdram_din, 16'h0);
    chk({tag, "_mask"}, sdram_mask, 2'b11);
    chk({tag, "_rdack"}, rd_ack, 1'b0);
    chk({tag, "_rdval"}, rd_valid, 1'b0);
    chk({tag, "_rddata"}, rd_data, 16'h0);
    chk({tag, "_ovf"}, overflow, 1'b0);
  endtask

  task automatic wait_read(output logic [15:0] data, output bit ok);
    ok = 1'b0;
    data = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rd_valid) begin
          ok = 1'b1;
          data = rd_data;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(string tag, logic [AW-1:0] a, logic [15:0] d);
    logic [15:0] got;
    bit ok;
    got_r.delete();
    rd_addr = a;
    sdram_dout = d;
    rd_req = 1'b1;
    wait_read(got, ok);
    chk({tag, "_done"}, ok, 1'b1);
    chk({tag, "_data"}, got, d);
    chk({tag, "_nrd"}, got_r.size(), 1);
    if (got_r.size() == 1) chk({tag, "_raddr"}, got_r[0], a);
  endtask

  // SDRAM responder: acks requests, logs them, returns read data
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      if (dst_cnt > 0) begin
        dst_cnt--;
        if (dst_cnt == 0) sdram_dst = 1'b1;
      end
      if (sdram_req && ack_en) begin
        sdram_ack = 1'b1;
        if (!sdram_wrn) begin
          got_w.push_back({sdram_addr, sdram_din, sdram_mask});
          ev_q.push_back(0);
        end else begin
          got_r.push_back(sdram_addr);
          ev_q.push_back(1);
          dst_cnt = dst_lat;
        end
      end
    end
  end

  // Bus monitor: strobes and request hold/release rules
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) vcnt++;
      if (rd_ack) acnt++;
      if (p_req && !p_ack && sdram_req &&
          {sdram_wrn, sdram_addr, sdram_din, sdram_mask} != p_bus)
        viol++;
      if (p_ack && sdram_req) viol++;
      p_req = sdram_req;
      p_ack = sdram_ack;
      p_bus = {sdram_wrn, sdram_addr, sdram_din, sdram_mask};
    end
  end

  initial begin
    logic [15:0] d;
    bit ok;
    logic [24:0] a;
    int n, v0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    tick(1);

    // Two bytes of one word
    downloading = 1'b1;
    tick(1);
    send_byte(25'd0, 8'h11, 2);
    send_byte(25'd1, 8'h22, 2);
    wait_writes();
    chk("w044_n", got_w.size(), 1);
    if (got_w.size() > 0) chk("w044", got_w[0], {22'd0, 16'h2211, 2'b00});
    drain_check("m044");

    // Lone even byte flushed by the end of download
    send_byte(25'd4, 8'hAA, 2);
    end_dl();
    wait_writes();
    chk("w045_n", got_w.size(), 1);
    if (got_w.size() > 0) chk("w045", got_w[0], {22'd2, 16'h00AA, 2'b10});
    drain_check("m045");

    // FIFO overflow with the bus stalled
    downloading = 1'b1;
    ack_en = 1'b0;
    tick(1);
    for (int k = 0; k < 6; k++) begin
      send_byte(25'(20 + 2 * k), 8'(8'h30 + k), 1);
      send_byte(25'(21 + 2 * k), 8'(8'hC0 + k), 1);
    end
    tick(3);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_nowr", got_w.size(), 0);
    void'(exp_w.pop_back());
    void'(exp_w.pop_back());
    end_dl();
    ack_en = 1'b1;
    drain_check("ovf");
    chk("ovf_sticky", overflow, 1'b1);
    do_reset();
    chk("ovf_clr", overflow, 1'b0);

    // Read held off by download
    downloading = 1'b1;
    tick(1);
    acnt = 0;
    vcnt = 0;
    got_r.delete();
    rd_addr = 22'h2A5A5;
    sdram_dout = 16'hBEEF;
    rd_req = 1'b1;
    tick(10);
    chk("r047_held", acnt, 0);
    downloading = 1'b0;
    wait_read(d, ok);
    chk("r047_done", ok, 1'b1);
    chk("r047_data", d, 16'hBEEF);
    chk("r047_ack", acnt, 1);
    chk("r047_nrd", got_r.size(), 1);
    if (got_r.size() == 1) chk("r047_addr", got_r[0], 22'h2A5A5);
    tick(5);
    chk("r047_val", vcnt, 1);

    // Write beats read in the same idle cycle
    downloading = 1'b1;
    tick(1);
    send_byte(25'd10, 8'h5A, 1);
    rd_addr = 22'h1234;
    sdram_dout = 16'h7E57;
    rd_req = 1'b1;
    tick(1);
    ev_q.delete();
    got_w.delete();
    exp_w.delete();
    m_pend = 1'b0;
    downloading = 1'b0;
    wait_read(d, ok);
    chk("p048_done", ok, 1'b1);
    chk("p048_data", d, 16'h7E57);
    chk("p048_nev", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      chk("p048_first", ev_q[0], 0);
      chk("p048_second", ev_q[1], 1);
    end
    if (got_w.size() > 0) chk("p048_wr", got_w[0], {22'd5, 16'h005A, 2'b10});
    got_w.delete();

    // Reset while waiting for read data
    dst_lat = 6;
    rd_addr = 22'h777;
    rd_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chk("r049_ack", ok, 1'b1);
    tick(1);
    rst_n = 1'b0;
    m_pend = 1'b0;
    tick(1);
    rst_n = 1'b1;
    v0 = vcnt;
    tick(12);
    chk("r049_noval", vcnt, v0);
    chk_reset("r049");
    dst_lat = 2;

    // Random downloads and reads
    for (int r = 0; r < 4; r++) begin
      downloading = 1'b1;
      tick(1);
      a = 25'($urandom_range(0, 1 << 20));
      n = $urandom_range(6, 20);
      for (int i = 0; i < n; i++) begin
        send_byte(a, 8'($urandom), $urandom_range(1, 3));
        a = a + 25'($urandom_range(1, 3));
      end
      end_dl();
      drain_check($sformatf("rnd%0d", r));
      do_read($sformatf("rrd%0d", r), 22'($urandom), 16'($urandom));
    end
    chk("rnd_ovf", overflow, 1'b0);
    chk("bus_rules", viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    errs++;
    $display("FAIL timeout errors=%0d", errs);
    $fatal(1, "timeout");
  end

endmodule
